ospfb_impulse_src: RTL and testbench

AXI4-Stream impulse stimulus transmitter feeding the OSPFB input path (source → dual-clock FIFO → ospfb). It emits complex samples that are zero everywhere except a programmable impulse value at a programmable sample index, optionally repeating with a fixed period. It stops after a fixed sample budget and flags completion for the bench. It is the producer counterpart of the AXIS capture VIP at the far end of the chain.

---
 rtl/ospfb_impulse_src_pkg.sv | 20 ++
 rtl/ospfb_impulse_src_if.sv | 12 +
 rtl/ospfb_beat_counter.sv | 24 ++
 rtl/ospfb_impulse_src.sv | 115 +++++++++++
 tb/tb_ospfb_impulse_src.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/ospfb_impulse_src_pkg.sv
// Shared types for the OSPFB impulse stimulus source: FSM state encoding and
// the complex sample layout carried on tdata.
package ospfb_impulse_src_pkg;

    localparam int CPLX_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } ospfb_src_state_t;

    // Matches the tdata packing {im, re}.
    typedef struct packed {
        logic signed [CPLX_W-1:0] im;
        logic signed [CPLX_W-1:0] re;
    } cplx_t;

endpackage

// File: rtl/ospfb_impulse_src_if.sv
// AXI4-Stream link between the impulse source and its consumer.
interface ospfb_impulse_src_if #(
    parameter int WIDTH = 16
);
    logic [2*WIDTH-1:0] tdata;
    logic               tvalid;
    logic               tready;
    logic               tlast;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/ospfb_beat_counter.sv
// Down-counting wrap counter: starts at TERM, steps toward zero, flags zero
// and reloads TERM on the step that leaves zero.
module ospfb_beat_counter #(
    parameter int TERM = 7
) (
    input  logic clk,
    input  logic rst,
    input  logic step,
    output logic wrap
);
    localparam int W = (TERM > 0) ? $clog2(TERM + 1) : 1;

    logic [W-1:0] count;

    assign wrap = (count == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= W'(TERM);
        end else if (step) begin
            count <= wrap ? W'(TERM) : count - W'(1);
        end
    end
endmodule

// File: rtl/ospfb_impulse_src.sv
// AXI4-Stream impulse generator: zero samples except PULSE_VAL on the real part
// at IMPULSE_PHASE (optionally every IMPULSE_PERIOD after), SAMP beats total.
module ospfb_impulse_src
    import ospfb_impulse_src_pkg::*;
#(
    parameter int WIDTH          = 16,
    parameter int FFT_LEN        = 64,
    parameter int SAMP           = 2048,
    parameter int IMPULSE_PHASE  = 9,
    parameter int IMPULSE_PERIOD = 0,
    parameter int PULSE_VAL      = 4096,
    localparam int CW            = $clog2(SAMP + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    ospfb_impulse_src_if.master  axis,
    output logic                 done,
    output logic [CW-1:0]        beat_count
);
    localparam int                      PER_TERM = (IMPULSE_PERIOD > 0) ? IMPULSE_PERIOD - 1 : 0;
    localparam logic [CW-1:0]           LAST_IDX = CW'(SAMP - 1);
    localparam logic signed [WIDTH-1:0] PULSE    = WIDTH'(PULSE_VAL);

    if (PULSE_VAL > (2**(WIDTH-1)) - 1 || PULSE_VAL < -(2**(WIDTH-1))) begin : g_bad_pulse
        $error("ospfb_impulse_src: PULSE_VAL does not fit in WIDTH signed bits");
    end
    if (SAMP < 1) begin : g_bad_samp
        $error("ospfb_impulse_src: SAMP must be at least 1");
    end

    ospfb_src_state_t        state;
    logic [CW-1:0]           next_idx;
    logic                    armed;
    logic                    hs;
    logic                    load;
    logic                    phase_hit;
    logic                    hit;
    logic                    frm_wrap;
    logic                    per_wrap;
    logic signed [WIDTH-1:0] next_re;

    // next_idx and both counters always describe the beat that will be loaded next.
    assign hs        = (state == RUN) && axis.tvalid && axis.tready;
    assign load      = (state == LOAD) || (hs && (beat_count != LAST_IDX) && en);
    assign phase_hit = (int'(next_idx) == IMPULSE_PHASE);
    assign hit       = phase_hit || ((IMPULSE_PERIOD != 0) && armed && per_wrap);
    assign next_re   = hit ? PULSE : '0;

    ospfb_beat_counter #(.TERM(FFT_LEN - 1)) u_frame_cnt (
        .clk  (clk),
        .rst  (rst),
        .step (load),
        .wrap (frm_wrap)
    );

    // Period counter only runs once the first impulse has been loaded.
    ospfb_beat_counter #(.TERM(PER_TERM)) u_period_cnt (
        .clk  (clk),
        .rst  (rst),
        .step (load && armed),
        .wrap (per_wrap)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            axis.tvalid <= 1'b0;
            axis.tdata  <= '0;
            axis.tlast  <= 1'b0;
            done        <= 1'b0;
            beat_count  <= '0;
            next_idx    <= '0;
            armed       <= 1'b0;
        end else begin
            if (load) begin
                axis.tvalid <= 1'b1;
                axis.tdata  <= {{WIDTH{1'b0}}, next_re};
                axis.tlast  <= frm_wrap;
                next_idx    <= next_idx + CW'(1);
                if (phase_hit) begin
                    armed <= 1'b1;
                end
            end else if (hs) begin
                axis.tvalid <= 1'b0;
                axis.tdata  <= '0;
                axis.tlast  <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (en) begin
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    state <= RUN;
                end
                RUN: begin
                    if (hs) begin
                        beat_count <= beat_count + CW'(1);
                        if (beat_count == LAST_IDX) begin
                            done  <= 1'b1;
                            state <= DONE;
                        end else if (!en) begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ospfb_impulse_src.sv
// Directed bench for ospfb_impulse_src: three configurations sharing one clock,
// selected one at a time, with expected beats derived from a modulo model.
module tb_ospfb_impulse_src;
    import ospfb_impulse_src_pkg::*;

    localparam int W    = 16;
    localparam int FLEN = 8;
    localparam int NS   = 32;
    localparam int CW   = $clog2(NS + 1);

    logic clk = 1'b0;
    logic rst;
    logic en;
    logic rdy;
    int   sel;

    always #5 clk = ~clk;

    ospfb_impulse_src_if #(.WIDTH(W)) ifa ();
    ospfb_impulse_src_if #(.WIDTH(W)) ifb ();
    ospfb_impulse_src_if #(.WIDTH(W)) ifc ();

    logic          done_a, done_b, done_c;
    logic [CW-1:0] cnt_a, cnt_b, cnt_c;
    logic          en_a, en_b, en_c;

    assign en_a       = (sel == 0) && en;
    assign en_b       = (sel == 1) && en;
    assign en_c       = (sel == 2) && en;
    assign ifa.tready = (sel == 0) && rdy;
    assign ifb.tready = (sel == 1) && rdy;
    assign ifc.tready = (sel == 2) && rdy;

    ospfb_impulse_src #(.WIDTH(W), .FFT_LEN(FLEN), .SAMP(NS), .IMPULSE_PHASE(9),
                        .IMPULSE_PERIOD(0), .PULSE_VAL(4096)) dut_a (
        .clk(clk), .rst(rst), .en(en_a), .axis(ifa), .done(done_a), .beat_count(cnt_a));

    ospfb_impulse_src #(.WIDTH(W), .FFT_LEN(FLEN), .SAMP(NS), .IMPULSE_PHASE(9),
                        .IMPULSE_PERIOD(8), .PULSE_VAL(4096)) dut_b (
        .clk(clk), .rst(rst), .en(en_b), .axis(ifb), .done(done_b), .beat_count(cnt_b));

    ospfb_impulse_src #(.WIDTH(W), .FFT_LEN(FLEN), .SAMP(NS), .IMPULSE_PHASE(40),
                        .IMPULSE_PERIOD(0), .PULSE_VAL(4096)) dut_c (
        .clk(clk), .rst(rst), .en(en_c), .axis(ifc), .done(done_c), .beat_count(cnt_c));

    logic [2*W-1:0] cur_tdata;
    logic           cur_tvalid;
    logic           cur_tlast;
    logic           cur_done;
    logic [CW-1:0]  cur_count;

    always_comb begin
        cur_tdata  = ifc.tdata;
        cur_tvalid = ifc.tvalid;
        cur_tlast  = ifc.tlast;
        cur_done   = done_c;
        cur_count  = cnt_c;
        if (sel == 0) begin
            cur_tdata  = ifa.tdata;
            cur_tvalid = ifa.tvalid;
            cur_tlast  = ifa.tlast;
            cur_done   = done_a;
            cur_count  = cnt_a;
        end else if (sel == 1) begin
            cur_tdata  = ifb.tdata;
            cur_tvalid = ifb.tvalid;
            cur_tlast  = ifb.tlast;
            cur_done   = done_b;
            cur_count  = cnt_b;
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    logic [2*W-1:0] cap_data [64];
    logic           cap_last [64];
    int             cap_idx  [64];
    int             ncap;
    logic [2*W-1:0] ref_data [64];
    logic           ref_last [64];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic int model_re(input int n);
        int ph;
        int per;
        ph  = (sel == 2) ? 40 : 9;
        per = (sel == 1) ? 8 : 0;
        if (n == ph) return 4096;
        if (per != 0 && n > ph && ((n - ph) % per) == 0) return 4096;
        return 0;
    endfunction

    task automatic do_reset(input int s);
        en  = 1'b0;
        rdy = 1'b0;
        sel = s;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_tvalid", 64'(cur_tvalid), 64'(0));
        chk("rst_tdata",  64'(cur_tdata),  64'(0));
        chk("rst_tlast",  64'(cur_tlast),  64'(0));
        chk("rst_done",   64'(cur_done),   64'(0));
        chk("rst_count",  64'(cur_count),  64'(0));
    endtask

    // Entered and left on a falling edge; records every handshake.
    task automatic capture(input bit rnd, input int budget);
        logic [2*W-1:0] hold_d;
        logic           hold_l;
        bit             stalled;
        int             cyc;
        ncap    = 0;
        stalled = 1'b0;
        hold_d  = '0;
        hold_l  = 1'b0;
        cyc     = 0;
        while (!cur_done && cyc < budget) begin
            if (stalled) begin
                chk("stall_tvalid", 64'(cur_tvalid), 64'(1));
                chk("stall_tdata",  64'(cur_tdata),  64'(hold_d));
                chk("stall_tlast",  64'(cur_tlast),  64'(hold_l));
            end
            rdy = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
            if (cur_tvalid && rdy && ncap < 64) begin
                cap_data[ncap] = cur_tdata;
                cap_last[ncap] = cur_tlast;
                cap_idx[ncap]  = int'(cur_count);
                ncap++;
            end
            stalled = cur_tvalid && !rdy;
            hold_d  = cur_tdata;
            hold_l  = cur_tlast;
            @(negedge clk);
            cyc++;
        end
        chk("capture_done", 64'(cur_done), 64'(1));
    endtask

    task automatic check_stream(input int start, input int nexp);
        cplx_t c;
        chk("beat_total", 64'(ncap), 64'(nexp));
        for (int k = 0; k < ncap; k++) begin
            c = cplx_t'(cap_data[k]);
            chk("beat_idx",  64'(cap_idx[k]),  64'(start + k));
            chk("beat_re",   64'(int'(c.re)),  64'(model_re(start + k)));
            chk("beat_im",   64'(int'(c.im)),  64'(0));
            chk("beat_last", 64'(cap_last[k]), 64'(((start + k) % FLEN) == FLEN - 1));
        end
        rdy = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("post_tvalid", 64'(cur_tvalid), 64'(0));
            chk("post_done",   64'(cur_done),   64'(1));
            chk("post_count",  64'(cur_count),  64'(NS));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   guard;
        logic [2*W-1:0] held;
        rst = 1'b1;
        en  = 1'b0;
        rdy = 1'b0;
        sel = 0;

        // Single impulse, full-rate ready, start latency.
        do_reset(0);
        rdy = 1'b1;
        en  = 1'b1;
        @(negedge clk);
        chk("lat_tvalid_1", 64'(cur_tvalid), 64'(0));
        @(negedge clk);
        chk("lat_tvalid_2", 64'(cur_tvalid), 64'(1));
        chk("lat_count",    64'(cur_count),  64'(0));
        capture(1'b0, 200);
        check_stream(0, NS);
        for (int k = 0; k < 64; k++) begin
            ref_data[k] = cap_data[k];
            ref_last[k] = cap_last[k];
        end

        // Random backpressure must reproduce the same stream.
        do_reset(0);
        en = 1'b1;
        capture(1'b1, 1000);
        check_stream(0, NS);
        for (int k = 0; k < ncap; k++) begin
            chk("bp_vs_ref_data", 64'(cap_data[k]), 64'(ref_data[k]));
            chk("bp_vs_ref_last", 64'(cap_last[k]), 64'(ref_last[k]));
        end

        // en dropped while beat 5 is stalled.
        do_reset(0);
        en    = 1'b1;
        rdy   = 1'b1;
        guard = 0;
        while (!(cur_tvalid && cur_count == CW'(5)) && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        chk("beat5_reached", 64'(cur_count), 64'(5));
        rdy  = 1'b0;
        en   = 1'b0;
        held = cur_tdata;
        repeat (3) begin
            @(negedge clk);
            chk("hold_tvalid", 64'(cur_tvalid), 64'(1));
            chk("hold_tdata",  64'(cur_tdata),  64'(held));
            chk("hold_count",  64'(cur_count),  64'(5));
        end
        rdy = 1'b1;
        @(negedge clk);
        chk("drop_tvalid", 64'(cur_tvalid), 64'(0));
        chk("drop_count",  64'(cur_count),  64'(6));
        @(negedge clk);
        chk("idle_tvalid", 64'(cur_tvalid), 64'(0));
        chk("idle_count",  64'(cur_count),  64'(6));
        en = 1'b1;
        @(negedge clk);
        chk("resume_tvalid_1", 64'(cur_tvalid), 64'(0));
        @(negedge clk);
        chk("resume_tvalid_2", 64'(cur_tvalid), 64'(1));
        capture(1'b0, 200);
        check_stream(6, NS - 6);

        // Asynchronous reset between clock edges mid-run.
        do_reset(0);
        en  = 1'b1;
        rdy = 1'b1;
        repeat (12) @(negedge clk);
        chk("pre_arst_tvalid", 64'(cur_tvalid), 64'(1));
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_tvalid", 64'(cur_tvalid), 64'(0));
        chk("arst_tdata",  64'(cur_tdata),  64'(0));
        chk("arst_tlast",  64'(cur_tlast),  64'(0));
        chk("arst_count",  64'(cur_count),  64'(0));
        @(negedge clk);
        rst = 1'b0;
        capture(1'b0, 200);
        check_stream(0, NS);

        // Periodic impulse: beats 9, 17, 25.
        do_reset(1);
        en = 1'b1;
        capture(1'b0, 200);
        check_stream(0, NS);

        // Impulse phase beyond the sample budget: all zeros.
        do_reset(2);
        en = 1'b1;
        capture(1'b0, 200);
        check_stream(0, NS);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
